xor_4b: RTL and testbench

- Bitwise exclusive-OR of two 4-bit operands; a leaf ALU primitive used by the datapath logic unit.
- Primary result `out` is purely combinational, so the existing positional instantiation (x, y, out) keeps working.
- Adds a clocked copy of the result plus two derived flags, `neq` and `parity`, for pipelined consumers.
- One clock domain; asynchronous active-high reset affects only the registered outputs.

---
 rtl/xor_4b.sv | 34 +++
 tb/tb_xor_4b.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/xor_4b.sv
// rtl/xor_4b.sv - 4-bit bitwise XOR with registered copy and neq/parity flags
module xor_4b #(
  // Block name fixes the width; only 4 is supported.
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] out,
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] out_q,
  output logic             neq,
  output logic             parity
);

  // Combinational result and flags; independent of clk and rst so they stay
  // valid during reset and keep the legacy (x, y, out) positional usage intact.
  always_comb begin
    out    = x ^ y;
    neq    = |out;
    parity = ^out;
  end

  // Pipelined copy of the result; rst clears it immediately and holds it at 0,
  // and is tested first so an edge coinciding with reset release leaves 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= x ^ y;
    end
  end

endmodule

// File: tb/tb_xor_4b.sv
// tb/tb_xor_4b.sv - table-driven self-checking bench for xor_4b
module tb_xor_4b;

  logic       clk;
  logic       rst;
  logic [3:0] x;
  logic [3:0] y;
  logic [3:0] out;
  logic [3:0] out_q;
  logic       neq;
  logic       parity;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] out;
    logic       neq;
    logic       parity;
  } vec_t;

  vec_t vecs [10];

  xor_4b #(.WIDTH(4)) dut (
    .x      (x),
    .y      (y),
    .out    (out),
    .clk    (clk),
    .rst    (rst),
    .out_q  (out_q),
    .neq    (neq),
    .parity (parity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (x=%b y=%b)", name, act, exp, x, y);
    end
  endtask

  function automatic logic [3:0] model_xor(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (a[i] != b[i]);
    return r;
  endfunction

  function automatic logic model_parity(input logic [3:0] a, input logic [3:0] b);
    int ones;
    ones = 0;
    for (int i = 0; i < 4; i++) if (a[i] != b[i]) ones++;
    return (ones % 2) == 1;
  endfunction

  initial begin
    vecs[0] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
    vecs[1] = '{4'b1000, 4'b0000, 4'b1000, 1'b1, 1'b1};
    vecs[2] = '{4'b1000, 4'b1001, 4'b0001, 1'b1, 1'b1};
    vecs[3] = '{4'b1101, 4'b1001, 4'b0100, 1'b1, 1'b1};
    vecs[4] = '{4'b1101, 4'b0110, 4'b1011, 1'b1, 1'b1};
    vecs[5] = '{4'b1010, 4'b1010, 4'b0000, 1'b0, 1'b0};
    vecs[6] = '{4'b0101, 4'b1111, 4'b1010, 1'b1, 1'b0};
    vecs[7] = '{4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0};
    vecs[8] = '{4'b0011, 4'b0000, 4'b0011, 1'b1, 1'b0};
    vecs[9] = '{4'b0111, 4'b0001, 4'b0110, 1'b1, 1'b0};

    rst = 1'b0;
    x   = 4'b0000;
    y   = 4'b0000;

    // Power-up: reset pulse clears out_q before any clock edge.
    #2 rst = 1'b1;
    #1;
    chk("reset_out_q_no_edge", out_q, 4'b0000);
    chk("reset_out", out, 4'b0000);
    chk("reset_neq", {3'b0, neq}, 4'b0000);
    chk("reset_parity", {3'b0, parity}, 4'b0000);

    // Flags stay live during reset while out_q holds 0 across an edge.
    x = 4'b1000;
    #1;
    chk("in_reset_out", out, 4'b1000);
    chk("in_reset_parity", {3'b0, parity}, 4'b0001);
    @(posedge clk);
    #1;
    chk("in_reset_out_q_hold", out_q, 4'b0000);
    @(negedge clk);
    rst = 1'b0;

    // Directed table: combinational outputs same timestep, out_q one edge later.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      x = vecs[i].x;
      y = vecs[i].y;
      #1;
      chk($sformatf("vec%0d_out", i), out, vecs[i].out);
      chk($sformatf("vec%0d_neq", i), {3'b0, neq}, {3'b0, vecs[i].neq});
      chk($sformatf("vec%0d_parity", i), {3'b0, parity}, {3'b0, vecs[i].parity});
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_out_q", i), out_q, vecs[i].out);
    end

    // Exhaustive sweep against a bitwise model.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        x = 4'(a);
        y = 4'(b);
        #1;
        chk("sweep_out", out, model_xor(4'(a), 4'(b)));
        chk("sweep_neq", {3'b0, neq}, {3'b0, (a != b)});
        chk("sweep_parity", {3'b0, parity}, {3'b0, model_parity(4'(a), 4'(b))});
        if (b == 15) chk("sweep_complement", out, ~(4'(a)));
      end
    end

    // Async reset mid-stream.
    @(negedge clk);
    x = 4'b1101;
    y = 4'b0110;
    @(posedge clk);
    #1;
    chk("mid_out_q_loaded", out_q, 4'b1011);
    #2 rst = 1'b1;
    #1;
    chk("mid_async_clear", out_q, 4'b0000);
    chk("mid_out_live", out, 4'b1011);
    @(posedge clk);
    #1;
    chk("mid_hold_in_reset", out_q, 4'b0000);

    // Release coincident with a rising edge: reset wins for that edge.
    @(posedge clk);
    rst <= 1'b0;
    #1;
    chk("release_edge_stays_zero", out_q, 4'b0000);
    @(posedge clk);
    #1;
    chk("first_edge_after_release", out_q, 4'b1011);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
